// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - writeback, debug and register-file write buses of the write arbiter
interface regfile_write_arbiter_if;
    logic        WbWrite;
    logic [4:0]  WbAddr;
    logic [31:0] WbData;
    logic        WbStall;

    logic        DbgReq;
    logic [4:0]  DbgAddr;
    logic [31:0] DbgData;
    logic        DbgAck;

    logic        RegWrite;
    logic [4:0]  RegWrAddr;
    logic [31:0] RegWrData;

    modport master (
        output WbWrite, WbAddr, WbData, DbgReq, DbgAddr, DbgData,
        input  WbStall, DbgAck, RegWrite, RegWrAddr, RegWrData
    );

    modport slave (
        input  WbWrite, WbAddr, WbData, DbgReq, DbgAddr, DbgData,
        output WbStall, DbgAck, RegWrite, RegWrAddr, RegWrData
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register file write-port arbiter with zero-clear sequencer
module regfile_write_arbiter #(
    parameter int MAX_WAIT       = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Init,
    output logic                          Busy,
    regfile_write_arbiter_if.slave        Bus
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [3:0] MaxWait = MAX_WAIT[3:0];

    state_t      State;
    state_t      NextState;
    logic [4:0]  ClrCnt;
    logic [3:0]  WaitCnt;

    logic        Pending;
    logic        Force;
    logic        GrantWb;
    logic        GrantDbg;
    logic        StallC;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            State <= CLEAR_ON_RESET ? CLEAR : RUN;
        end else begin
            State <= NextState;
        end
    end

    // Init during the final clear cycle keeps us in CLEAR for a full restart.
    always_comb begin
        NextState = State;
        case (State)
            CLEAR:   if (!Init && ClrCnt == 5'd31) NextState = RUN;
            RUN:     if (Init) NextState = CLEAR;
            default: NextState = State;
        endcase
    end

    // A debug request is not pending during its own ack cycle, which blocks a double write.
    always_comb begin
        Pending  = Bus.DbgReq && !Bus.DbgAck;
        Force    = 1'b0;
        GrantWb  = 1'b0;
        GrantDbg = 1'b0;
        StallC   = 1'b0;
        if (State == CLEAR) begin
            StallC = 1'b1;
        end else begin
            Force = Pending && (WaitCnt >= MaxWait);
            if (Force) begin
                GrantDbg = 1'b1;
                StallC   = 1'b1;
            end else if (Bus.WbWrite) begin
                GrantWb = 1'b1;
            end else if (Pending) begin
                GrantDbg = 1'b1;
            end
        end
    end

    assign Bus.WbStall = StallC;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Bus.RegWrite  <= 1'b0;
            Bus.RegWrAddr <= 5'd0;
            Bus.RegWrData <= 32'd0;
            Bus.DbgAck    <= 1'b0;
            WaitCnt       <= 4'd0;
            ClrCnt        <= 5'd1;
            Busy          <= CLEAR_ON_RESET;
        end else begin
            Busy       <= (NextState == CLEAR);
            Bus.DbgAck <= GrantDbg;
            if (State == CLEAR) begin
                Bus.RegWrite  <= 1'b1;
                Bus.RegWrAddr <= ClrCnt;
                Bus.RegWrData <= 32'd0;
                ClrCnt        <= Init ? 5'd1 : ClrCnt + 5'd1;
            end else begin
                if (Init) begin
                    ClrCnt <= 5'd1;
                end
                // Register 0 is hardwired; its writes are arbitrated but never enabled.
                if (GrantDbg) begin
                    Bus.RegWrite  <= (Bus.DbgAddr != 5'd0);
                    Bus.RegWrAddr <= Bus.DbgAddr;
                    Bus.RegWrData <= Bus.DbgData;
                end else if (GrantWb) begin
                    Bus.RegWrite  <= (Bus.WbAddr != 5'd0);
                    Bus.RegWrAddr <= Bus.WbAddr;
                    Bus.RegWrData <= Bus.WbData;
                end else begin
                    Bus.RegWrite <= 1'b0;
                end
                if (!Bus.DbgReq || GrantDbg) begin
                    WaitCnt <= 4'd0;
                end else if (Pending && WaitCnt != 4'd15) begin
                    WaitCnt <= WaitCnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
    localparam int MAX_WAIT       = 4;
    localparam bit CLEAR_ON_RESET = 1'b1;

    logic Clk = 1'b0;
    logic Reset;
    logic Init;
    logic Busy;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(
        .MAX_WAIT       (MAX_WAIT),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Init  (Init),
        .Busy  (Busy),
        .Bus   (bus)
    );

    always #5 Clk = ~Clk;

    int nCompared   = 0;
    int nMismatched = 0;

    // reference model: clear progress, debug wait age and the expected registered outputs
    bit          mValid = 1'b0;
    bit          mClearing;
    int          mNextClr;
    int          mWait;
    bit          mStall;
    bit          eRegWrite, eAck, eBusy, eFresh;
    logic [4:0]  eAddr;
    logic [31:0] eData;
    logic [31:0] mRegs [32];
    logic [31:0] dRegs [32];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        bit pend, frc, gDbg, gWb;
        @(negedge Clk);
        pend = bus.DbgReq && !eAck;
        frc  = !mClearing && pend && (mWait >= MAX_WAIT);
        if (mValid) begin
            if (bus.RegWrite === 1'b1) dRegs[bus.RegWrAddr] = bus.RegWrData;
            if (eRegWrite) mRegs[eAddr] = eData;
            check_eq("WbStall", 32'(bus.WbStall), 32'(mClearing || frc));
            check_eq("RegWrite", 32'(bus.RegWrite), 32'(eRegWrite));
            check_eq("DbgAck", 32'(bus.DbgAck), 32'(eAck));
            check_eq("Busy", 32'(Busy), 32'(eBusy));
            if (eRegWrite || eFresh) begin
                check_eq("RegWrAddr", 32'(bus.RegWrAddr), 32'(eAddr));
                check_eq("RegWrData", bus.RegWrData, eData);
            end
        end
        mStall = mClearing || frc;
        if (Reset) begin
            mValid = 1'b1;  eFresh = 1'b1;
            eRegWrite = 1'b0; eAck = 1'b0; eAddr = 5'd0; eData = 32'd0;
            mWait = 0; mClearing = CLEAR_ON_RESET; mNextClr = 1; eBusy = CLEAR_ON_RESET;
        end else if (mClearing) begin
            eFresh = 1'b0;
            eRegWrite = 1'b1; eAddr = 5'(mNextClr); eData = 32'd0; eAck = 1'b0;
            if (Init) mNextClr = 1;
            else if (mNextClr == 31) mClearing = 1'b0;
            else mNextClr++;
            eBusy = mClearing;
        end else begin
            eFresh = 1'b0;
            gDbg = frc || (!bus.WbWrite && pend);
            gWb  = !frc && bus.WbWrite;
            eAck = gDbg;
            if (gDbg) begin
                eRegWrite = (bus.DbgAddr != 5'd0);
                if (eRegWrite) begin eAddr = bus.DbgAddr; eData = bus.DbgData; end
            end else if (gWb) begin
                eRegWrite = (bus.WbAddr != 5'd0);
                if (eRegWrite) begin eAddr = bus.WbAddr; eData = bus.WbData; end
            end else begin
                eRegWrite = 1'b0;
            end
            if (!bus.DbgReq || gDbg) mWait = 0;
            else if (pend && mWait < 15) mWait++;
            if (Init) begin mClearing = 1'b1; mNextClr = 1; end
            eBusy = mClearing;
        end
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [4:0] rand_addr();
        rand_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    endfunction

    task automatic drive_random();
        Reset = ($urandom_range(0, 399) == 0);
        Init  = ($urandom_range(0, 149) == 0);
        if (!(bus.WbWrite && mStall)) begin
            bus.WbWrite = ($urandom_range(0, 99) < 60);
            bus.WbAddr  = rand_addr();
            bus.WbData  = $urandom;
        end
        if (bus.DbgReq && !eAck) begin
            bus.DbgReq = 1'b1;
        end else if ((bus.DbgReq && $urandom_range(0, 1) == 0) || (!bus.DbgReq && $urandom_range(0, 3) == 0)) begin
            bus.DbgReq  = 1'b1;
            bus.DbgAddr = rand_addr();
            bus.DbgData = $urandom;
        end else begin
            bus.DbgReq = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mRegs[i] = 32'hA5A5_0000 | 32'(i);
            dRegs[i] = mRegs[i];
        end
        Reset = 1'b1; Init = 1'b0;
        bus.WbWrite = 1'b0; bus.WbAddr = 5'd0; bus.WbData = 32'd0;
        bus.DbgReq = 1'b0; bus.DbgAddr = 5'd0; bus.DbgData = 32'd0;
        repeat (3) tick();
        check_eq("reset_busy", 32'(Busy), 32'd1);
        check_eq("reset_regwrite", 32'(bus.RegWrite), 32'd0);
        Reset = 1'b0;
        repeat (35) tick();
        for (int i = 1; i < 32; i++) check_eq("clear_reg", dRegs[i], 32'd0);
        check_eq("clear_reg0_untouched", dRegs[0], 32'hA5A5_0000);
        check_eq("clear_done_busy", 32'(Busy), 32'd0);
        check_eq("clear_done_stall", 32'(bus.WbStall), 32'd0);

        // plain writeback
        bus.WbWrite = 1'b1; bus.WbAddr = 5'd5; bus.WbData = 32'hDEAD_BEEF;
        tick();
        check_eq("wb_write", 32'(bus.RegWrite), 32'd1);
        check_eq("wb_addr", 32'(bus.RegWrAddr), 32'd5);
        check_eq("wb_data", bus.RegWrData, 32'hDEAD_BEEF);
        bus.WbWrite = 1'b0;
        tick();

        // debug only, request held past the ack
        bus.DbgReq = 1'b1; bus.DbgAddr = 5'd7; bus.DbgData = 32'h1234_5678;
        tick();
        check_eq("dbg_ack", 32'(bus.DbgAck), 32'd1);
        check_eq("dbg_addr", 32'(bus.RegWrAddr), 32'd7);
        check_eq("dbg_data", bus.RegWrData, 32'h1234_5678);
        tick();
        check_eq("dbg_no_double", 32'(bus.RegWrite), 32'd0);
        bus.DbgReq = 1'b0;
        tick();

        // continuous writeback starving a debug request
        bus.WbWrite = 1'b1; bus.WbAddr = 5'd3; bus.WbData = 32'h0000_0333;
        bus.DbgReq = 1'b1; bus.DbgAddr = 5'd9; bus.DbgData = 32'h9999_0009;
        repeat (MAX_WAIT) begin
            #1 check_eq("starve_no_stall", 32'(bus.WbStall), 32'd0);
            tick();
        end
        #1 check_eq("force_stall", 32'(bus.WbStall), 32'd1);
        tick();
        check_eq("force_ack", 32'(bus.DbgAck), 32'd1);
        check_eq("force_addr", 32'(bus.RegWrAddr), 32'd9);
        bus.DbgReq = 1'b0;
        tick();
        check_eq("wb_resume_addr", 32'(bus.RegWrAddr), 32'd3);
        bus.WbWrite = 1'b0;

        // Init with a pending debug write, then reset partway through the clear
        bus.DbgReq = 1'b1; bus.DbgAddr = 5'd12; bus.DbgData = 32'hC0DE_0012;
        Init = 1'b1;
        tick();
        check_eq("init_dbg_ack", 32'(bus.DbgAck), 32'd1);
        check_eq("init_dbg_addr", 32'(bus.RegWrAddr), 32'd12);
        check_eq("init_busy", 32'(Busy), 32'd1);
        Init = 1'b0; bus.DbgReq = 1'b0;
        tick();
        check_eq("init_clear_first", 32'(bus.RegWrAddr), 32'd1);
        repeat (9) tick();
        check_eq("clear_cycle10", 32'(bus.RegWrAddr), 32'd10);
        Reset = 1'b1;
        tick();
        check_eq("midclear_reset_we", 32'(bus.RegWrite), 32'd0);
        check_eq("midclear_reset_addr", 32'(bus.RegWrAddr), 32'd0);
        Reset = 1'b0;
        tick();
        check_eq("restart_addr", 32'(bus.RegWrAddr), 32'd1);
        repeat (35) tick();

        // address 0 from both sources
        bus.WbWrite = 1'b1; bus.WbAddr = 5'd0; bus.WbData = 32'hFFFF_FFFF;
        tick();
        check_eq("wb_addr0_we", 32'(bus.RegWrite), 32'd0);
        bus.WbWrite = 1'b0;
        bus.DbgReq = 1'b1; bus.DbgAddr = 5'd0; bus.DbgData = 32'hFFFF_FFFF;
        tick();
        check_eq("dbg_addr0_ack", 32'(bus.DbgAck), 32'd1);
        check_eq("dbg_addr0_we", 32'(bus.RegWrite), 32'd0);
        bus.DbgReq = 1'b0;
        tick();

        repeat (4000) begin
            drive_random();
            tick();
        end
        Reset = 1'b0; Init = 1'b0; bus.WbWrite = 1'b0; bus.DbgReq = 1'b0;
        repeat (2) tick();
        for (int i = 0; i < 32; i++) check_eq("regfile", dRegs[i], mRegs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
